uart_rx_cfg: RTL and testbench



---
 rtl/uart_rx_cfg.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
//   Frame: 1 start bit, DATA_BITS data bits (LSB first), optional odd/even
//   parity bit, STOP_BITS stop bits. Reports parity and framing errors with
//   each received word. The serial input is brought into the clock domain by a
//   2-flop synchronizer before any decision is taken.
//
// Optional feature: define UART_RX_MAJORITY_EN to sample every bit three times
//   (MID-1, MID, MID+1) and take the 2-of-3 majority at MID+1. This shifts all
//   sample points and o_Rx_DV one clock later.
//
// Ports:
//   i_Clock      system clock, all logic on the rising edge
//   i_Reset      synchronous reset, active-high
//   i_Rx_Serial  asynchronous serial line, idle high
//   o_Rx_DV      one-cycle pulse, o_Rx_Byte and the error flags are valid
//   o_Rx_Byte    last received word (DATA_BITS wide)
//   o_Parity_Err parity mismatch on the last word (0 when PARITY_MODE=0)
//   o_Frame_Err  a stop bit was sampled low on the last word
//   o_Busy       high whenever the receiver is not idle
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_BITS    = 9,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int MID   = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_DEC = MID + 1;
`else
  localparam int START_DEC = MID;
`endif
  // Decision counts: the start bit is judged near its middle, every later bit
  // one full bit period after the previous decision.
  localparam logic [CNT_W-1:0] START_DEC_C = CNT_W'(START_DEC);
  localparam logic [CNT_W-1:0] BIT_DEC_C   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    DONE       = 3'd5,
    BREAK_WAIT = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 dv_q;
  logic [DATA_BITS-1:0] byte_q;
  logic                 perr_out_q, ferr_out_q;
  logic                 busy_q;
  logic                 load_out_s;
  logic                 line_s, bit_s, at_dec_s;
  logic [CNT_W-1:0]     dec_cnt_s;

  // Odd mode expects an odd number of ones across data plus parity bit.
  function automatic logic parity_err(input logic [DATA_BITS-1:0] data, input logic pbit);
    logic x;
    x = ^data ^ pbit;
    if (PARITY_MODE == 1) begin
      parity_err = ~x;
    end else begin
      parity_err = x;
    end
  endfunction

`ifdef UART_RX_MAJORITY_EN
  logic maj_a_q, maj_b_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  assign bit_s = maj3(maj_a_q, maj_b_q, line_s);
`else
  assign bit_s = line_s;
`endif

  assign line_s    = sync2_q;
  assign dec_cnt_s = (state_q == START) ? START_DEC_C : BIT_DEC_C;
  assign at_dec_s  = (cnt_q == dec_cnt_s);

  // Next-state logic for the frame receiver.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    load_out_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d      = {CNT_W{1'b0}};
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        stop_idx_d = 1'b0;
        if (!line_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (at_dec_s) begin
          cnt_d = {CNT_W{1'b0}};
          idx_d = {IDX_W{1'b0}};
          // A start bit that is high again by mid-bit is a glitch.
          state_d = bit_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (at_dec_s) begin
          cnt_d          = {CNT_W{1'b0}};
          shift_d[idx_q] = bit_s;
          if (idx_q == LAST_IDX) begin
            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (at_dec_s) begin
          cnt_d   = {CNT_W{1'b0}};
          perr_d  = parity_err(shift_q, bit_s);
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (at_dec_s) begin
          cnt_d  = {CNT_W{1'b0}};
          ferr_d = ferr_q | ~bit_s;
          if ((STOP_BITS == 2) && (stop_idx_q == 1'b0)) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d    = DONE;
            load_out_s = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      DONE: begin
        // A low stop bit may be the start of a break; wait for idle first.
        state_d = ferr_q ? BREAK_WAIT : IDLE;
      end
      BREAK_WAIT: begin
        if (line_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      stop_idx_q <= 1'b0;
      shift_q    <= {DATA_BITS{1'b0}};
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= {DATA_BITS{1'b0}};
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= i_Rx_Serial;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      dv_q       <= load_out_s;
      busy_q     <= (state_d != IDLE);
      if (load_out_s) begin
        byte_q     <= shift_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ferr_d;
      end else begin
        byte_q     <= byte_q;
        perr_out_q <= perr_out_q;
        ferr_out_q <= ferr_out_q;
      end
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Capture the two early votes, two and one clocks before each decision.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      maj_a_q <= 1'b1;
      maj_b_q <= 1'b1;
    end else begin
      if (cnt_q == dec_cnt_s - CNT_W'(2)) begin
        maj_a_q <= line_s;
      end
      if (cnt_q == dec_cnt_s - CNT_W'(1)) begin
        maj_b_q <= line_s;
      end
    end
  end
`endif

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg. Three receivers with different frame formats share
// one clock and reset; each has its own serial line. A frame-level model
// predicts, for every frame sent, the word, error flags and the clock cycle
// at which o_Rx_DV must pulse; a single compare process checks every cycle.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
  localparam int MID = (CPB - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;
  logic [2:0] dv, perr, ferr, busy;
  logic [7:0] byte0, byte2;
  logic [8:0] byte1;
  logic [8:0] obyte [3];

  always #5 clk = ~clk;

  assign obyte[0] = {1'b0, byte0};
  assign obyte[1] = byte1;
  assign obyte[2] = {1'b0, byte2};

  // 8N1
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Byte(byte0),
    .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Busy(busy[0]));
  // 9E1
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Byte(byte1),
    .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Busy(busy[1]));
  // 8N2
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Byte(byte2),
    .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Busy(busy[2]));

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t       expq [3][$];
  logic [8:0] m_byte [3];
  logic       m_perr [3];
  logic       m_ferr [3];
  int         dv_cnt [3];
  int         cyc    = 0;
  int         n_pass = 0;
  int         n_chk  = 0;
  bit         armed  = 1'b0;

  task automatic check(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame on line 'inst' and record what the receiver must report.
  // Latency: 2 synchronizer clocks + 1 clock to leave idle + MID (+1 with
  // majority voting) to the start decision, one bit period per remaining bit,
  // then 1 clock to DV.
  task automatic send_frame(int inst, logic [8:0] data, int nbits, int pmode,
                            logic pbit, int nstop, logic stop_val, bit glitch);
    logic bits [$];
    exp_t e;
    logic x;
    bits.push_back(1'b0);
    for (int k = 0; k < nbits; k++) bits.push_back(data[k]);
    if (pmode != 0) bits.push_back(pbit);
    for (int k = 0; k < nstop; k++) bits.push_back(stop_val);
    x = 1'b0;
    e.data = 9'h000;
    for (int k = 0; k < nbits; k++) begin
      x = x ^ data[k];
      e.data[k] = data[k];
    end
    if (pmode == 1) e.perr = ((x ^ pbit) == 1'b0);
    else if (pmode == 2) e.perr = ((x ^ pbit) == 1'b1);
    else e.perr = 1'b0;
    e.ferr = (stop_val == 1'b0);
    e.cyc  = cyc + MID + 4 + MAJ + CPB * (bits.size() - 1);
    expq[inst].push_back(e);
    for (int b = 0; b < bits.size(); b++) begin
      for (int j = 0; j < CPB; j++) begin
        if (glitch && b >= 1 && b <= nbits && j == MID) rx[inst] = ~bits[b];
        else rx[inst] = bits[b];
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Per-cycle comparison of all receivers against the frame model.
  initial begin : compare
    bit rst_s;
    bit exp_dv;
    exp_t e;
    for (int i = 0; i < 3; i++) dv_cnt[i] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      rst_s = rst;
      @(negedge clk);
      if (rst_s) begin
        armed = 1'b1;
        for (int i = 0; i < 3; i++) begin
          m_byte[i] = 9'h000;
          m_perr[i] = 1'b0;
          m_ferr[i] = 1'b0;
          check($sformatf("rst_busy%0d", i), busy[i], 0);
        end
      end
      if (armed) begin
        for (int i = 0; i < 3; i++) begin
          exp_dv = (!rst_s && expq[i].size() != 0 && expq[i][0].cyc == cyc);
          check($sformatf("dv%0d", i), dv[i], exp_dv);
          if (!rst_s && dv[i]) dv_cnt[i]++;
          if (exp_dv) begin
            e = expq[i].pop_front();
            m_byte[i] = e.data;
            m_perr[i] = e.perr;
            m_ferr[i] = e.ferr;
          end
          check($sformatf("byte%0d", i), obyte[i], m_byte[i]);
          check($sformatf("perr%0d", i), perr[i], m_perr[i]);
          check($sformatf("ferr%0d", i), ferr[i], m_ferr[i]);
        end
      end
    end
  end

  initial begin : stim
    int t0;
    bit saw;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2 * CPB);

    // 1: plain 8N1 word
    send_frame(0, 9'h03F, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    tick(4);
    check("t1_byte", obyte[0], 'h3F);
    check("t1_perr", perr[0], 0);
    check("t1_ferr", ferr[0], 0);
    check("t1_dvcnt", dv_cnt[0], 1);

    // 2: 9 data bits, even parity; 0x1AB has six ones
    send_frame(1, 9'h1AB, 9, 2, 1'b0, 1, 1'b1, 1'b0);
    tick(4);
    check("t2a_byte", obyte[1], 'h1AB);
    check("t2a_perr", perr[1], 0);
    send_frame(1, 9'h1AB, 9, 2, 1'b1, 1, 1'b1, 1'b0);
    tick(4);
    check("t2b_byte", obyte[1], 'h1AB);
    check("t2b_perr", perr[1], 1);

    // 3: low stop bit followed by a 3-bit break, then a clean frame
    send_frame(0, 9'h081, 8, 0, 1'b0, 1, 1'b0, 1'b0);
    tick(3 * CPB);
    check("t3_ferr", ferr[0], 1);
    check("t3_byte", obyte[0], 'h81);
    check("t3_break_dvcnt", dv_cnt[0], 2);
    rx[0] = 1'b1;
    tick(2 * CPB);
    send_frame(0, 9'h055, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    tick(4);
    check("t3_byte55", obyte[0], 'h55);
    check("t3_ferr55", ferr[0], 0);
    check("t3_dvcnt", dv_cnt[0], 3);

    // 5: reset pulse in the middle of data bit 3
    rx[0] = 1'b0;
    tick(4 * CPB + CPB / 2);
    rst = 1'b1;
    tick(1);
    rst   = 1'b0;
    rx[0] = 1'b1;
    check("t5_rst_byte", obyte[0], 0);
    check("t5_rst_dv", dv[0], 0);
    check("t5_rst_busy", busy[0], 0);
    check("t5_rst_ferr", ferr[0], 0);
    check("t5_rst_byte1", obyte[1], 0);
    check("t5_rst_perr1", perr[1], 0);
    tick(2 * CPB);
    check("t5_abort_dvcnt", dv_cnt[0], 3);
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b0);
    tick(4);
    check("t5_byte", obyte[0], 'hA5);
    check("t5_dvcnt", dv_cnt[0], 4);

    // 4: 4-clock low glitch on an idle line
    t0    = cyc;
    rx[0] = 1'b0;
    tick(4);
    rx[0] = 1'b1;
    saw   = 1'b0;
    while (cyc < t0 + MID + 5) begin
      @(negedge clk);
      if (busy[0]) saw = 1'b1;
    end
    check("t4_busy_seen", saw, 1);
    check("t4_busy_idle", busy[0], 0);
    @(posedge clk);
    #1;
    tick(2 * CPB);
    check("t4_dvcnt", dv_cnt[0], 4);

    // 6: back-to-back 8N2 frames (mid-bit glitches when voting is enabled)
    send_frame(2, 9'h012, 8, 0, 1'b0, 2, 1'b1, MAJ == 1);
    send_frame(2, 9'h034, 8, 0, 1'b0, 2, 1'b1, MAJ == 1);
    tick(4);
    check("t6_byte", obyte[2], 'h34);
    check("t6_ferr", ferr[2], 0);
    check("t6_dvcnt", dv_cnt[2], 2);

    tick(2 * CPB);
    for (int i = 0; i < 3; i++) check($sformatf("pending%0d", i), expq[i].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
